exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Parametrised successor to the fixed FETCH/EXEC1/EXEC2 control state machine; sits between the instruction decoder and the datapath control decode.
- Sequences FETCH then a decoder-selected count of 1..MAX_EXEC execute cycles, with stall hold and a retired-instruction counter.
- State is held in registers inside the block; the next-state logic is no longer exported.

Parameters:
- MAX_EXEC, 4, maximum number of execute cycles per instruction; legal range 2..15.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- NCYCLES  input  CW  decoder's execute-cycle count for the current instruction; CW = $clog2(MAX_EXEC+1).
- STALL  input  1  holds the current phase, e.g. for a memory wait.
- FETCH  output  1  high in the fetch phase.
- EXEC  output  MAX_EXEC  one-hot execute phase; bit k-1 is high in EXECk.
- PHASE  output  CW  0 = FETCH, k = EXECk.
- LAST  output  1  high in the final execute cycle of the current instruction.
- INSTR_DONE  output  1  retire strobe: LAST & !STALL.
- INSTR_COUNT  output  CNT_W  number of retired instructions.

Behaviour:
- Reset is synchronous, active-high, and takes priority over all other inputs.
  - Reset values: state = FETCH (FETCH=1, EXEC=0, PHASE=0), limit register = 1, INSTR_COUNT = 0, LAST = 0, INSTR_DONE = 0.
  - Reset asserted mid-instruction abandons that instruction; nothing is retired.
- FETCH, EXEC, PHASE and LAST are Moore outputs decoded from registered state. INSTR_DONE is the only Mealy output.
- FETCH phase:
  - STALL=1: hold.
  - STALL=0: next state is EXEC1.
- EXEC1 phase:
  - NCYCLES is sampled only here, because the instruction register is valid from EXEC1 onward. It is ignored in all other phases.
  - Clamp on sampling: 0 -> 1; values > MAX_EXEC -> MAX_EXEC.
  - LAST in EXEC1 = (clamped NCYCLES == 1), evaluated combinationally.
  - STALL=1: hold. NCYCLES is re-sampled on each held cycle, and the value present on the advancing cycle wins.
  - STALL=0 and clamped value == 1: retire and go to FETCH.
  - STALL=0 and clamped value > 1: store it in the limit register and go to EXEC2.
- EXECk phase, k >= 2:
  - LAST = (k == limit).
  - STALL=1: hold.
  - STALL=0 and LAST: retire and go to FETCH.
  - STALL=0 otherwise: go to EXEC(k+1).
- Retire: INSTR_DONE is high for exactly one cycle per instruction. INSTR_COUNT increments on that edge and wraps from 2^CNT_W-1 to 0.
- Invariants:
  - Exactly one of FETCH and the EXEC bits is high, except in HALTED (see Optional Feature).
  - PHASE never exceeds MAX_EXEC.
  - Unreachable state encodings recover to FETCH on the next edge.
- Instruction length: for N clamped execute cycles with no stalls, one instruction takes N+1 cycles. Each stall cycle adds exactly one cycle.

Optional Feature:
- Macro: EXEC_SEQ_HALT_EN.
- With the macro defined:
  - Adds input HALT (1) and output HALTED (1); HALTED resets to 0.
  - If HALT=1 on a retire cycle, the next state is HALTED instead of FETCH.
  - In HALTED: FETCH=0, EXEC=0, PHASE=0, HALTED=1.
  - Leaving HALTED: HALT=0 gives FETCH on the next edge. STALL is ignored while halted.
  - HALT in any non-retire cycle has no effect.
- Without the macro: the HALT and HALTED ports are absent, and retire always goes to FETCH.

Decomposition:
- Package exec_seq_pkg contains:
  - Default MAX_EXEC and CNT_W.
  - A function computing CW.
  - PH_FETCH = 0.
  - A state enum: S_FETCH, S_EXEC, S_HALT. The execute index is held in a separate register.
- One sub-module, retire_counter: CNT_W-bit synchronous counter with reset and an increment enable driven by INSTR_DONE.

Test Plan:
- Reset, then NCYCLES=1 and STALL=0 held constant -> PHASE sequence 0,1,0,1,...; INSTR_DONE high in every EXEC1 cycle; INSTR_COUNT=3 after 6 cycles.
- NCYCLES=3 sampled in EXEC1, then the input changes to 1 -> PHASE 0,1,2,3,0; LAST high only at PHASE=3; EXEC one-hot values 0001, 0010, 0100.
- NCYCLES=0 -> clamps to 1 (PHASE 0,1,0). NCYCLES=7 with MAX_EXEC=4 -> clamps to 4 (PHASE 0,1,2,3,4,0).
- STALL=1 for 2 cycles in EXEC2 of a 3-cycle instruction -> PHASE 0,1,2,2,2,3,0; INSTR_DONE pulses exactly once; INSTR_COUNT increments by 1.
- CNT_W=4: retire 16 instructions -> INSTR_COUNT wraps 15->0. Reset asserted in EXEC2 -> FETCH next cycle and INSTR_COUNT=0.
- With EXEC_SEQ_HALT_EN: HALT=1 at retire -> HALTED=1, FETCH=0 for 3 cycles. HALT deasserted -> FETCH=1 next cycle. HALT=1 during EXEC1 of a 2-cycle instruction but 0 at retire -> no halt.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the execute-phase sequencer.
// Optional halt support is enabled by defining EXEC_SEQ_HALT_EN.
package exec_seq_pkg;

  localparam int DEF_MAX_EXEC = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int PH_FETCH     = 0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  // Width of NCYCLES / PHASE: must hold 0..max_exec.
  function automatic int calc_cw(input int max_exec);
    return $clog2(max_exec + 1);
  endfunction

endpackage

// File: rtl/exec_sequencer_retire_counter.sv
// Retired-instruction counter: wraps naturally at 2^CNT_W.
module retire_counter
  import exec_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  // NOTE: non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/exec_sequencer.sv
// FETCH followed by 1..MAX_EXEC execute cycles, with stall hold and retire count.
// Define EXEC_SEQ_HALT_EN to add the HALT input and HALTED output.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int  MAX_EXEC = DEF_MAX_EXEC,
  parameter int  CNT_W    = DEF_CNT_W,
  localparam int CW       = calc_cw(MAX_EXEC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CW-1:0]       NCYCLES,
  input  logic                STALL,
  output logic                FETCH,
  output logic [MAX_EXEC-1:0] EXEC,
  output logic [CW-1:0]       PHASE,
  output logic                LAST,
  output logic                INSTR_DONE,
  output logic [CNT_W-1:0]    INSTR_COUNT
`ifdef EXEC_SEQ_HALT_EN
  ,
  input  logic                HALT,
  output logic                HALTED
`endif
);

  localparam logic [CW-1:0] IDX_ONE = CW'(1);
  localparam logic [CW-1:0] IDX_MAX = CW'(MAX_EXEC);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] limit_q, limit_d;
  logic [CW-1:0] ncyc_clamped;
  logic          exec_valid;
  logic          halt_req;

`ifdef EXEC_SEQ_HALT_EN
  assign halt_req = HALT;
  assign HALTED   = (state_q == S_HALT);
`else
  assign halt_req = 1'b0;
`endif

  always_comb begin
    ncyc_clamped = NCYCLES;
    if (NCYCLES == '0)          ncyc_clamped = IDX_ONE;
    else if (NCYCLES > IDX_MAX) ncyc_clamped = IDX_MAX;
  end

  // A corrupted index counts as an unreachable state and falls back to FETCH.
  assign exec_valid = (state_q == S_EXEC) && (idx_q != '0) && (idx_q <= IDX_MAX);

  always_comb begin
    FETCH = (state_q == S_FETCH);
    PHASE = exec_valid ? idx_q : CW'(PH_FETCH);
    EXEC  = '0;
    for (int k = 1; k <= MAX_EXEC; k++) EXEC[k-1] = exec_valid && (idx_q == CW'(k));
    LAST = 1'b0;
    if (exec_valid) begin
      // EXEC1 has no stored limit yet; the decoder count is live here.
      if (idx_q == IDX_ONE) LAST = (ncyc_clamped == IDX_ONE);
      else                  LAST = (idx_q >= limit_q) || (idx_q == IDX_MAX);
    end
  end

  assign INSTR_DONE = LAST & ~STALL & ~reset;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    limit_d = limit_q;
    case (state_q)
      S_FETCH: begin
        if (!STALL) begin
          state_d = S_EXEC;
          idx_d   = IDX_ONE;
        end
      end
      S_EXEC: begin
        if (!exec_valid) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else if (!STALL) begin
          if (LAST) begin
            state_d = halt_req ? S_HALT : S_FETCH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
            if (idx_q == IDX_ONE) limit_d = ncyc_clamped;
          end
        end
      end
      S_HALT: begin
        if (!halt_req) state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      idx_q   <= '0;
      limit_q <= IDX_ONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      limit_q <= limit_d;
    end
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk  (clk),
    .reset(reset),
    .en   (INSTR_DONE),
    .count(INSTR_COUNT)
  );

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer (default build and EXEC_SEQ_HALT_EN).
module tb_exec_sequencer;
  import exec_seq_pkg::*;

  localparam int MAXE = 4;
  localparam int CW   = calc_cw(MAXE);

  typedef struct packed {
    logic          stall;
    logic [CW-1:0] ncyc;
    logic [CW-1:0] phase;
    logic          last;
    logic          done;
  } row_t;

  typedef struct packed {
    logic [CW-1:0] phase;
    logic          last;
    logic          done;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   ncycles;
  logic            stall;
  logic            fetch, last, instr_done;
  logic [MAXE-1:0] exec;
  logic [CW-1:0]   phase;
  logic [15:0]     count;
  logic            fetch4, last4, done4;
  logic [MAXE-1:0] exec4;
  logic [CW-1:0]   phase4;
  logic [3:0]      count4;
`ifdef EXEC_SEQ_HALT_EN
  logic            halt;
  logic            halted, halted4;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.MAX_EXEC(MAXE), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .NCYCLES(ncycles), .STALL(stall),
    .FETCH(fetch), .EXEC(exec), .PHASE(phase), .LAST(last),
    .INSTR_DONE(instr_done), .INSTR_COUNT(count)
`ifdef EXEC_SEQ_HALT_EN
    , .HALT(halt), .HALTED(halted)
`endif
  );

  exec_sequencer #(.MAX_EXEC(MAXE), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .NCYCLES(ncycles), .STALL(stall),
    .FETCH(fetch4), .EXEC(exec4), .PHASE(phase4), .LAST(last4),
    .INSTR_DONE(done4), .INSTR_COUNT(count4)
`ifdef EXEC_SEQ_HALT_EN
    , .HALT(halt), .HALTED(halted4)
`endif
  );

  function automatic logic [MAXE-1:0] onehot(input logic [CW-1:0] ph);
    logic [MAXE-1:0] v;
    v = '0;
    if (ph != '0) v[ph-1] = 1'b1;
    return v;
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic s, input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    stall   = s;
    ncycles = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; ncycles = '0;
`ifdef EXEC_SEQ_HALT_EN
    halt = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL reset_fetch: got %b expected 1", fetch); end
    checks++; if (exec !== '0) begin errors++; $display("FAIL reset_exec: got %b expected 0", exec); end
    checks++; if (phase !== '0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", instr_done); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL reset_count4: got %0d expected 0", count4); end
`ifdef EXEC_SEQ_HALT_EN
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    exp_count = 0;
  endtask

  task automatic test_single();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{phase: CW'(i % 2), last: (i % 2 == 1), done: (i % 2 == 1)});
      drive(1'b0, CW'(1));
      e = exp_q.pop_front();
      checks++; if (phase !== e.phase) begin errors++; $display("FAIL single_phase[%0d]: got %0d expected %0d", i, phase, e.phase); end
      checks++; if (instr_done !== e.done) begin errors++; $display("FAIL single_done[%0d]: got %b expected %b", i, instr_done, e.done); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL single_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      if (e.done) exp_count++;
    end
  endtask

  task automatic test_multi();
    row_t rows[4] = '{
      '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd3, 3'd1, 1'b0, 1'b0},
      '{1'b0, 3'd1, 3'd2, 1'b0, 1'b0},
      '{1'b0, 3'd1, 3'd3, 1'b1, 1'b1}};
    exp_t e;
    foreach (rows[i]) begin
      exp_q.push_back('{phase: rows[i].phase, last: rows[i].last, done: rows[i].done});
      drive(rows[i].stall, rows[i].ncyc);
      e = exp_q.pop_front();
      checks++; if (phase !== e.phase) begin errors++; $display("FAIL multi_phase[%0d]: got %0d expected %0d", i, phase, e.phase); end
      checks++; if (last !== e.last) begin errors++; $display("FAIL multi_last[%0d]: got %b expected %b", i, last, e.last); end
      checks++; if (exec !== onehot(e.phase)) begin errors++; $display("FAIL multi_exec[%0d]: got %b expected %b", i, exec, onehot(e.phase)); end
      checks++; if (fetch !== (e.phase == '0)) begin errors++; $display("FAIL multi_fetch[%0d]: got %b expected %b", i, fetch, (e.phase == '0)); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL multi_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      if (e.done) exp_count++;
    end
  endtask

  task automatic test_clamp();
    row_t rows[10] = '{
      '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd0, 3'd1, 1'b1, 1'b1},
      '{1'b0, 3'd7, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd7, 3'd1, 1'b0, 1'b0},
      '{1'b0, 3'd0, 3'd2, 1'b0, 1'b0},
      '{1'b0, 3'd7, 3'd3, 1'b0, 1'b0},
      '{1'b0, 3'd1, 3'd4, 1'b1, 1'b1},
      '{1'b0, 3'd2, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0},
      '{1'b0, 3'd5, 3'd2, 1'b1, 1'b1}};
    exp_t e;
    foreach (rows[i]) begin
      exp_q.push_back('{phase: rows[i].phase, last: rows[i].last, done: rows[i].done});
      drive(rows[i].stall, rows[i].ncyc);
      e = exp_q.pop_front();
      checks++; if (phase !== e.phase) begin errors++; $display("FAIL clamp_phase[%0d]: got %0d expected %0d", i, phase, e.phase); end
      checks++; if (last !== e.last) begin errors++; $display("FAIL clamp_last[%0d]: got %b expected %b", i, last, e.last); end
      checks++; if (instr_done !== e.done) begin errors++; $display("FAIL clamp_done[%0d]: got %b expected %b", i, instr_done, e.done); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL clamp_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      if (e.done) exp_count++;
    end
  endtask

  task automatic test_stall();
    row_t rows[13] = '{
      '{1'b1, 3'd3, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd3, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd3, 3'd1, 1'b0, 1'b0},
      '{1'b1, 3'd3, 3'd2, 1'b0, 1'b0},
      '{1'b1, 3'd3, 3'd2, 1'b0, 1'b0},
      '{1'b0, 3'd3, 3'd2, 1'b0, 1'b0},
      '{1'b1, 3'd3, 3'd3, 1'b1, 1'b0},
      '{1'b0, 3'd3, 3'd3, 1'b1, 1'b1},
      '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0},
      '{1'b1, 3'd1, 3'd1, 1'b1, 1'b0},
      '{1'b1, 3'd3, 3'd1, 1'b0, 1'b0},
      '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0},
      '{1'b0, 3'd5, 3'd2, 1'b1, 1'b1}};
    exp_t e;
    foreach (rows[i]) begin
      exp_q.push_back('{phase: rows[i].phase, last: rows[i].last, done: rows[i].done});
      drive(rows[i].stall, rows[i].ncyc);
      e = exp_q.pop_front();
      checks++; if (phase !== e.phase) begin errors++; $display("FAIL stall_phase[%0d]: got %0d expected %0d", i, phase, e.phase); end
      checks++; if (last !== e.last) begin errors++; $display("FAIL stall_last[%0d]: got %b expected %b", i, last, e.last); end
      checks++; if (instr_done !== e.done) begin errors++; $display("FAIL stall_done[%0d]: got %b expected %b", i, instr_done, e.done); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      if (e.done) exp_count++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back('{phase: CW'(i % 2), last: (i % 2 == 1), done: (i % 2 == 1)});
      drive(1'b0, CW'(1));
      e = exp_q.pop_front();
      checks++; if (count4 !== exp_count[3:0]) begin errors++; $display("FAIL wrap_count4[%0d]: got %0d expected %0d", i, count4, exp_count[3:0]); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      checks++; if (phase4 !== e.phase || exec4 !== onehot(e.phase) || fetch4 !== (e.phase == '0))
        begin errors++; $display("FAIL wrap_phase4[%0d]: got %0d/%b/%b expected %0d", i, phase4, exec4, fetch4, e.phase); end
      checks++; if (last4 !== e.last || done4 !== e.done)
        begin errors++; $display("FAIL wrap_done4[%0d]: got %b/%b expected %b/%b", i, last4, done4, e.last, e.done); end
      if (e.done) exp_count++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, CW'(2));
    drive(1'b0, CW'(2));
    @(posedge clk);
    #1;
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    checks++; if (phase !== CW'(2)) begin errors++; $display("FAIL rstmid_pre_phase: got %0d expected 2", phase); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    exp_count = 0;
    checks++; if (fetch !== 1'b1 || phase !== '0) begin errors++; $display("FAIL rstmid_fetch: got %b/%0d expected 1/0", fetch, phase); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL rstmid_count4: got %0d expected 0", count4); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", last); end
  endtask

`ifdef EXEC_SEQ_HALT_EN
  task automatic test_halt();
    // {stall, ncyc, halt, phase, last, done, halted}
    logic [10:0] rows[9] = '{
      {1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0},
      {1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0},
      {1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1},
      {1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1},
      {1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1},
      {1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1},
      {1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},
      {1'b0, 3'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0},
      {1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0}};
    logic [10:0] r;
    exp_t e;
    logic exp_halted;
    foreach (rows[i]) begin
      r = rows[i];
      exp_q.push_back('{phase: r[5:3], last: r[2], done: r[1]});
      exp_halted = r[0];
      @(posedge clk);
      #1;
      halt = r[6];
      drive_now(r[10], r[9:7]);
      e = exp_q.pop_front();
      checks++; if (halted !== exp_halted || halted4 !== exp_halted) begin errors++; $display("FAIL halt_halted[%0d]: got %b/%b expected %b", i, halted, halted4, exp_halted); end
      checks++; if (fetch !== (e.phase == '0 && !exp_halted)) begin errors++; $display("FAIL halt_fetch[%0d]: got %b expected %b", i, fetch, (e.phase == '0 && !exp_halted)); end
      checks++; if (phase !== e.phase || exec !== onehot(e.phase)) begin errors++; $display("FAIL halt_phase[%0d]: got %0d/%b expected %0d", i, phase, exec, e.phase); end
      checks++; if (instr_done !== e.done || last !== e.last) begin errors++; $display("FAIL halt_done[%0d]: got %b/%b expected %b/%b", i, last, instr_done, e.last, e.done); end
      checks++; if (count !== exp_count[15:0]) begin errors++; $display("FAIL halt_count[%0d]: got %0d expected %0d", i, count, exp_count); end
      if (e.done) exp_count++;
    end
    halt = 1'b0;
  endtask

  task automatic drive_now(input logic s, input logic [CW-1:0] n);
    stall   = s;
    ncycles = n;
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_clamp();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef EXEC_SEQ_HALT_EN
    test_halt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
